// File: rtl/ripple_count_sequencer_pkg.sv
// Shared definitions for the ripple-counter measurement sequencer.
package ripple_count_sequencer_pkg;

  localparam int CNT_W     = 4;
  localparam int CLR_LIMIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLR_PULSE,
    CLR_LOW,
    CLR_SETTLE,
    COUNT,
    SETTLE,
    CAPTURE,
    HOLD
  } state_t;

endpackage

// File: rtl/ripple_count_sequencer_ev_sync.sv
// Two-flop synchronizer for an asynchronous event line plus rising-edge detect.
// Latency: an edge on async_i shows up on rise_o two to three clocks later, for one cycle.
module ev_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic async_i,
  output logic rise_o
);

  logic [1:0] sync_q;
  logic       prev_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], async_i};
      prev_q <= sync_q[1];
    end
  end

  assign rise_o = sync_q[1] & ~prev_q;

endmodule

// File: rtl/ripple_count_sequencer.sv
// Clears an external 4-bit ripple counter, gates events into it for a window, then captures it.
// The result is held in HOLD until result_ready; start is accepted only in IDLE.
module ripple_count_sequencer
  import ripple_count_sequencer_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int WIN_W      = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             ev_in,
  input  logic [CNT_W-1:0] cnt_q,
  output logic             cnt_clk,
  output logic [CNT_W-1:0] cnt_t,
  output logic             busy,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overflow,
  output logic             mismatch,
  output logic             clr_err
);

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   rem_q, rem_d;
  logic [3:0]         settle_q, settle_d;
  logic [4:0]         clr_cnt_q, clr_cnt_d;
  logic [4:0]         shadow_q, shadow_d;
  logic               cnt_clk_q, cnt_clk_d;
  logic [CNT_W-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               mis_q, mis_d;
  logic               clr_err_q, clr_err_d;
  logic               ev_rise;
  logic               settle_adv;
  logic               settle_done;

  ev_sync u_ev_sync (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .async_i (ev_in),
    .rise_o  (ev_rise)
  );

  assign settle_done = (settle_q == 4'(SETTLE_CYC - 1));

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    clr_cnt_d  = clr_cnt_q;
    shadow_d   = shadow_q;
    result_d   = result_q;
    ovf_d      = ovf_q;
    mis_d      = mis_q;
    clr_err_d  = clr_err_q;
    cnt_clk_d  = 1'b0;
    settle_adv = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d     = win_len;
          clr_cnt_d = '0;
          shadow_d  = '0;
          ovf_d     = 1'b0;
          mis_d     = 1'b0;
          clr_err_d = 1'b0;
          state_d   = CLR_SETTLE;
        end
      end
      CLR_SETTLE: begin
        settle_adv = 1'b1;
        if (settle_done) begin
          if (cnt_q == '0) begin
            state_d = (rem_q == '0) ? SETTLE : COUNT;
          end else if (clr_cnt_q == 5'(CLR_LIMIT)) begin
            clr_err_d = 1'b1;
            state_d   = CAPTURE;
          end else begin
            cnt_clk_d = 1'b1;
            state_d   = CLR_PULSE;
          end
        end
      end
      CLR_PULSE: begin
        clr_cnt_d = clr_cnt_q + 5'd1;
        state_d   = CLR_LOW;
      end
      CLR_LOW: begin
        state_d = CLR_SETTLE;
      end
      COUNT: begin
        // Synchronized rises are at least two cycles apart, so each pulse gets a low cycle.
        if (ev_rise) begin
          cnt_clk_d = 1'b1;
          shadow_d  = (shadow_q == 5'd31) ? shadow_q : shadow_q + 5'd1;
        end
        rem_d = rem_q - WIN_W'(1);
        if (rem_q == WIN_W'(1)) begin
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // A pulse for an event seen in the last COUNT cycle may still be high here;
        // the settle time is measured from its falling edge.
        settle_adv = ~cnt_clk_q;
        if (settle_adv && settle_done) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        result_d = cnt_q;
        ovf_d    = (shadow_q > 5'd15);
        mis_d    = (cnt_q != shadow_q[3:0]);
        state_d  = HOLD;
      end
      HOLD: begin
        if (result_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d != state_q) begin
      settle_d = '0;
    end else if (settle_adv) begin
      settle_d = settle_q + 4'd1;
    end else begin
      settle_d = settle_q;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      settle_q  <= '0;
      clr_cnt_q <= '0;
      shadow_q  <= '0;
      cnt_clk_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      mis_q     <= 1'b0;
      clr_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      settle_q  <= settle_d;
      clr_cnt_q <= clr_cnt_d;
      shadow_q  <= shadow_d;
      cnt_clk_q <= cnt_clk_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      mis_q     <= mis_d;
      clr_err_q <= clr_err_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign cnt_t        = busy ? '1 : '0;
  assign cnt_clk      = cnt_clk_q;
  assign result       = result_q;
  assign result_valid = (state_q == HOLD);
  assign overflow     = ovf_q;
  assign mismatch     = mis_q;
  assign clr_err      = clr_err_q;

endmodule
